// File: rtl/core_bus_arbiter_pkg.sv
// Shared bus types and constants for the core bus arbiter.
package core_bus_arbiter_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned IDATA_W = 32;

  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1 = 8'd0;

  typedef logic [1:0] axi_burst_t;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic               addr_ok;
    logic               data_ok;
    logic [IDATA_W-1:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    msize_t            size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    mlen_t             len;
    axi_burst_t        burst;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  // Fetches become fixed 4-byte single-beat reads.
  function automatic cbus_req_t ireq_to_cbus(input logic [ADDR_W-1:0] addr);
    cbus_req_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.is_write = 1'b0;
    c.size     = MSIZE4;
    c.addr     = addr;
    c.strobe   = '0;
    c.len      = MLEN1;
    c.burst    = AXI_BURST_FIXED;
    return c;
  endfunction

  // Load/store: any strobe bit set marks a write.
  function automatic cbus_req_t dreq_to_cbus(input msize_t size, input logic [ADDR_W-1:0] addr,
                                             input logic [STRB_W-1:0] strobe,
                                             input logic [DATA_W-1:0] data);
    cbus_req_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.is_write = |strobe;
    c.size     = size;
    c.addr     = addr;
    c.strobe   = strobe;
    c.data     = data;
    c.len      = MLEN1;
    c.burst    = AXI_BURST_FIXED;
    return c;
  endfunction

endpackage

// File: rtl/core_bus_arbiter.sv
// Serializes instruction and data traffic onto one single-beat cbus transaction at a time.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state, state_n;
  cbus_req_t        req_q, req_n;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_n;
  logic             done;
  logic             grant_d;

  // State, latched request and starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      req_q      <= req_n;
      starve_cnt <= starve_cnt_n;
    end
  end

  // Grant decision, request translation and response routing.
  always_comb begin
    state_n      = state;
    req_n        = req_q;
    starve_cnt_n = starve_cnt;
    oreq         = '0;
    iresp        = '0;
    dresp        = '0;
    done         = oresp.ready && oresp.last;
    grant_d      = 1'b0;

    case (state)
      IDLE: begin
        // Data wins unless the waiting fetch has been passed over STARVE_LIMIT times.
        grant_d = dreq.valid && !(ireq.valid && (starve_cnt == CNT_MAX));
        if (grant_d) begin
          req_n   = dreq_to_cbus(dreq.size, dreq.addr, dreq.strobe, dreq.data);
          state_n = BUSY_D;
          if (!ireq.valid) begin
            starve_cnt_n = '0;
          end else if (starve_cnt != CNT_MAX) begin
            starve_cnt_n = starve_cnt + CNT_W'(1);
          end
        end else if (ireq.valid) begin
          req_n        = ireq_to_cbus(ireq.addr);
          state_n      = BUSY_I;
          starve_cnt_n = '0;
        end
      end
      BUSY_I: begin
        oreq = req_q;
        if (done) begin
          iresp.addr_ok = 1'b1;
          iresp.data_ok = 1'b1;
          iresp.data    = oresp.data[IDATA_W-1:0];
          state_n       = IDLE;
        end
      end
      BUSY_D: begin
        oreq = req_q;
        if (done) begin
          dresp.addr_ok = 1'b1;
          dresp.data_ok = 1'b1;
          dresp.data    = oresp.data;
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: vector table, directed corner cases, random traffic.
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  core_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .oreq  (oreq),
    .oresp (oresp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, what it asked for, how often a waiting fetch lost.
  bit        m_busy;
  bit        m_own_d;
  cbus_req_t m_req;
  int        m_streak;

  // Observations
  bit          i_ok, d_ok;
  int          i_ok_cnt, d_ok_cnt;
  logic [31:0] last_idata;
  bit          prev_ov;
  logic [63:0] grant_q[$];

  typedef struct {
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [7:0]  ds;
    logic [63:0] dd;
    logic        rdy;
    logic        lst;
    logic [63:0] rd;
    logic        e_ov;
    logic        e_wr;
    logic [63:0] e_addr;
    logic        e_iok;
    logic        e_dok;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_own_d  = 1'b0;
    m_req    = '0;
    m_streak = 0;
    prev_ov  = 1'b0;
    i_ok     = 1'b0;
    d_ok     = 1'b0;
  endtask

  // One cycle: inputs are already set (just after negedge); compare, clock, advance model.
  task automatic step();
    cbus_req_t  eo;
    ibus_resp_t ei;
    dbus_resp_t ed;
    bit         done;
    #1;
    eo   = m_busy ? m_req : '0;
    done = m_busy && oresp.ready && oresp.last;
    ei   = '0;
    ed   = '0;
    if (done && !m_own_d) begin
      ei.addr_ok = 1'b1; ei.data_ok = 1'b1; ei.data = oresp.data[31:0];
    end
    if (done && m_own_d) begin
      ed.addr_ok = 1'b1; ed.data_ok = 1'b1; ed.data = oresp.data;
    end
    chk("oreq",  192'(oreq),  192'(eo));
    chk("iresp", 192'(iresp), 192'(ei));
    chk("dresp", 192'(dresp), 192'(ed));
    i_ok = iresp.data_ok;
    d_ok = dresp.data_ok;
    if (i_ok) begin i_ok_cnt++; last_idata = iresp.data; end
    if (d_ok) d_ok_cnt++;
    if (oreq.valid && !prev_ov) grant_q.push_back(oreq.addr);
    prev_ov = oreq.valid;
    @(posedge clk);
    if (m_busy) begin
      if (done) m_busy = 1'b0;
    end else if (dreq.valid && !(ireq.valid && m_streak >= int'(LIMIT))) begin
      m_busy         = 1'b1;
      m_own_d        = 1'b1;
      m_req          = '0;
      m_req.valid    = 1'b1;
      m_req.is_write = (dreq.strobe != 8'h00);
      m_req.size     = dreq.size;
      m_req.addr     = dreq.addr;
      m_req.strobe   = dreq.strobe;
      m_req.data     = dreq.data;
      m_req.len      = MLEN1;
      m_req.burst    = AXI_BURST_FIXED;
      if (ireq.valid) m_streak = (m_streak < int'(LIMIT)) ? m_streak + 1 : int'(LIMIT);
      else            m_streak = 0;
    end else if (ireq.valid) begin
      m_busy      = 1'b1;
      m_own_d     = 1'b0;
      m_req       = '0;
      m_req.valid = 1'b1;
      m_req.size  = MSIZE4;
      m_req.addr  = ireq.addr;
      m_req.len   = MLEN1;
      m_req.burst = AXI_BURST_FIXED;
      m_streak    = 0;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_oreq",  192'(oreq),  192'(0));
    chk("rst_iresp", 192'(iresp), 192'(0));
    chk("rst_dresp", 192'(dresp), 192'(0));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_dreq(input logic v, input logic [63:0] a, input msize_t sz,
                          input logic [7:0] s, input logic [63:0] d);
    dreq.valid = v; dreq.addr = a; dreq.size = sz; dreq.strobe = s; dreq.data = d;
  endtask

  initial begin
    int i_base, d_base;
    clear_inputs();
    reset = 1'b1;
    model_reset();
    i_ok_cnt = 0;
    d_ok_cnt = 0;
    last_idata = '0;

    // Simultaneous store + fetch: store first, one-cycle bubble, then fetch.
    vecs[0] = '{1'b1, 64'h8000_0004, 1'b1, 64'h8000_1000, 8'hFF, 64'hDEAD_BEEF, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 64'h8000_0004, 1'b1, 64'h8000_1000, 8'hFF, 64'hDEAD_BEEF, 1'b0, 1'b0, 64'h0,
                1'b1, 1'b1, 64'h8000_1000, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 64'h8000_0004, 1'b1, 64'h8000_1000, 8'hFF, 64'hDEAD_BEEF, 1'b1, 1'b1, 64'h0,
                1'b1, 1'b1, 64'h8000_1000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                1'b1, 1'b0, 64'h8000_0004, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 1'b1, 64'h13,
                1'b1, 1'b0, 64'h8000_0004, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b0, 64'h0, 1'b0, 1'b0};

    do_reset();
    for (int k = 0; k < 7; k++) begin
      ireq.valid = vecs[k].iv;
      ireq.addr  = vecs[k].ia;
      set_dreq(vecs[k].dv, vecs[k].da, MSIZE8, vecs[k].ds, vecs[k].dd);
      oresp.ready = vecs[k].rdy;
      oresp.last  = vecs[k].lst;
      oresp.data  = vecs[k].rd;
      #1;
      chk($sformatf("vec%0d_ov", k), 192'(oreq.valid), 192'(vecs[k].e_ov));
      if (vecs[k].e_ov) begin
        chk($sformatf("vec%0d_wr", k),   192'(oreq.is_write), 192'(vecs[k].e_wr));
        chk($sformatf("vec%0d_addr", k), 192'(oreq.addr),     192'(vecs[k].e_addr));
      end
      chk($sformatf("vec%0d_iok", k), 192'(iresp.data_ok), 192'(vecs[k].e_iok));
      chk($sformatf("vec%0d_dok", k), 192'(dresp.data_ok), 192'(vecs[k].e_dok));
      step();
    end

    // Fetch only, three wait cycles before the response.
    do_reset();
    i_base = i_ok_cnt;
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0000;
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fetch_ov",   192'(oreq.valid),    192'(1));
      chk("fetch_rd",   192'(oreq.is_write), 192'(0));
      chk("fetch_size", 192'(oreq.size),     192'(MSIZE4));
      step();
    end
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'h0000_0013;
    step();
    ireq.valid = 1'b0;
    oresp = '0;
    step();
    step();
    chk("fetch_okcnt", 192'(i_ok_cnt - i_base), 192'(1));
    chk("fetch_data",  192'(last_idata),        192'(32'h13));

    // Starvation: continuous data traffic versus a waiting fetch, zero-wait target.
    do_reset();
    grant_q.delete();
    ireq.valid = 1'b1;
    ireq.addr  = 64'h2000;
    set_dreq(1'b1, 64'h1000, MSIZE8, 8'h00, 64'h0);
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'h55;
    for (int k = 0; k < 22; k++) step();
    clear_inputs();
    step();
    step();
    chk("starve_cnt", 192'(grant_q.size() >= 10), 192'(1));
    if (grant_q.size() >= 10) begin
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("starve_g%0d", k), 192'(grant_q[k]),
            192'(((k % 5) == 4) ? 64'h2000 : 64'h1000));
      end
    end

    // Payload change while busy must not reach oreq.
    do_reset();
    set_dreq(1'b1, 64'h3000, MSIZE4, 8'h0F, 64'h1234);
    step();
    dreq.addr = 64'h4000;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("latch_addr", 192'(oreq.addr), 192'(64'h3000));
      step();
    end
    oresp.ready = 1'b1; oresp.last = 1'b1;
    #1;
    chk("latch_addr_last", 192'(oreq.addr), 192'(64'h3000));
    step();
    clear_inputs();
    step();

    // Reset in the middle of a fetch.
    do_reset();
    i_base = i_ok_cnt;
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0040;
    step();
    step();
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'h77;
    reset = 1'b1;
    #1;
    chk("midrst_ov",  192'(oreq.valid),     192'(0));
    chk("midrst_iok", 192'(iresp.data_ok),  192'(0));
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    model_reset();
    oresp.ready = 1'b1; oresp.last = 1'b1;
    step();
    step();
    chk("midrst_okcnt", 192'(i_ok_cnt - i_base), 192'(0));

    // Spurious ready while idle.
    do_reset();
    i_base = i_ok_cnt;
    d_base = d_ok_cnt;
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'hABCD;
    for (int k = 0; k < 3; k++) step();
    chk("spur_iok", 192'(i_ok_cnt - i_base), 192'(0));
    chk("spur_dok", 192'(d_ok_cnt - d_base), 192'(0));
    oresp.ready = 1'b0;
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0100;
    step();
    #1;
    chk("spur_next_ov", 192'(oreq.valid), 192'(1));
    oresp.ready = 1'b1;
    step();
    clear_inputs();
    step();

    // Random traffic under the hold-until-data_ok contract.
    do_reset();
    i_base = i_ok_cnt;
    d_base = d_ok_cnt;
    for (int k = 0; k < 3000; k++) begin
      if (!ireq.valid || i_ok) begin
        ireq.valid = ($urandom_range(0, 2) == 0);
        ireq.addr  = {32'h0, $urandom};
      end
      if (!dreq.valid || d_ok) begin
        set_dreq(($urandom_range(0, 2) == 0), {32'h0, $urandom}, msize_t'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom});
      end
      oresp.ready = ($urandom_range(0, 1) == 1);
      oresp.last  = ($urandom_range(0, 7) != 0);
      oresp.data  = {$urandom, $urandom};
      step();
    end
    chk("rand_iprog", 192'((i_ok_cnt - i_base) > 50), 192'(1));
    chk("rand_dprog", 192'((d_ok_cnt - d_base) > 50), 192'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
